// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-channel synchroniser and glitch filter,
// 4x decoding into a wrap-around count. Define QUAD_INDEX_EN to add the Z index input.
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 16,
  parameter int DIR_INV     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
`ifdef QUAD_INDEX_EN
  input  logic             enc_z,
`endif
  input  logic             clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
`ifdef QUAD_INDEX_EN
  output logic             index_seen,
`endif
  output logic             err
);

`ifdef QUAD_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif
  localparam int FCW      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int INIT_LEN = SYNC_STAGES + FILT_LEN + 1;
  localparam int ICW      = $clog2(INIT_LEN);
  localparam logic FWD_DIR = (DIR_INV == 0);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] filt;

`ifdef QUAD_INDEX_EN
  assign raw = {enc_z, enc_b, enc_a};
`else
  assign raw = {enc_b, enc_a};
`endif

  // Each channel: shift-register synchroniser, then a run-length filter that
  // only follows the synced value after FILT_LEN consecutive differing samples.
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FCW-1:0]         cnt_q;
    logic                   filt_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign filt[g] = filt_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[g]};
        if (synced == filt_q) begin
          cnt_q <= '0;
        end else if (cnt_q == FCW'(FILT_LEN - 1)) begin
          filt_q <= synced;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + FCW'(1);
        end
      end
    end
  end

  logic [0:0]     state_q;
  logic [ICW-1:0] init_cnt_q;
  logic [1:0]     cur;
  logic [1:0]     prev_q;
  logic           run;
  logic           fwd;
  logic           rev;
  logic           ill;
  logic           idx_hit;

  assign cur = {filt[0], filt[1]};
  assign run = (state_q == ST_RUN);

  // Gray order {a,b}: 00 -> 01 -> 11 -> 10 -> 00 is forward.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    ill = 1'b0;
    case ({prev_q, cur})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = run;
      4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = run;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: ill = run;
      default: ;
    endcase
  end

`ifdef QUAD_INDEX_EN
  logic prev_z_q;
  assign idx_hit = run && filt[2] && !prev_z_q;
`else
  assign idx_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= 2'b00;
      count      <= '0;
      dir        <= 1'b0;
      step       <= 1'b0;
      err        <= 1'b0;
    end else begin
      prev_q <= cur;
      step   <= 1'b0;

      if (state_q == ST_INIT) begin
        if (init_cnt_q == ICW'(INIT_LEN - 1)) begin
          state_q <= ST_RUN;
        end else begin
          init_cnt_q <= init_cnt_q + ICW'(1);
        end
      end

      // clr beats the index edge, which beats a decoded step; dir only
      // follows steps that are actually applied.
      if (clr) begin
        count <= '0;
      end else if (idx_hit) begin
        count <= '0;
      end else if (fwd) begin
        count <= count + CNT_W'(1);
        dir   <= FWD_DIR;
        step  <= 1'b1;
      end else if (rev) begin
        count <= count - CNT_W'(1);
        dir   <= ~FWD_DIR;
        step  <= 1'b1;
      end

      if (ill) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

`ifdef QUAD_INDEX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_z_q   <= 1'b0;
      index_seen <= 1'b0;
    end else begin
      prev_z_q <= filt[2];
      if (clr) begin
        index_seen <= 1'b0;
      end else if (idx_hit) begin
        index_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: two differently parameterised instances share the
// inputs and are compared every cycle against a behavioural model.
module tb_quad_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enc_a, enc_b, enc_z, clr, err_clr;
  logic [15:0] a_count, b_count;
  logic a_dir, a_step, a_err, b_dir, b_step, b_err;
`ifdef QUAD_INDEX_EN
  logic a_idx, b_idx;
  localparam bit IDX_EN = 1'b1;
`else
  localparam bit IDX_EN = 1'b0;
`endif

  quad_decoder #(.SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(16), .DIR_INV(0)) dut_a (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
`ifdef QUAD_INDEX_EN
    .enc_z(enc_z), .index_seen(a_idx),
`endif
    .clr(clr), .err_clr(err_clr),
    .count(a_count), .dir(a_dir), .step(a_step), .err(a_err)
  );

  quad_decoder #(.SYNC_STAGES(3), .FILT_LEN(1), .CNT_W(16), .DIR_INV(1)) dut_b (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
`ifdef QUAD_INDEX_EN
    .enc_z(enc_z), .index_seen(b_idx),
`endif
    .clr(clr), .err_clr(err_clr),
    .count(b_count), .dir(b_dir), .step(b_step), .err(b_err)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;
  int steps_a = 0;
  int cur_g = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [15:0] ha, hb, hz;
    logic fa, fb, fz, pa, pb, pz;
    logic run, dir, step, err, idx;
    logic [15:0] cnt;
    logic [7:0]  init_left;
  } mdl_t;

  mdl_t m [2];
  int s_p [2] = '{2, 3};
  int f_p [2] = '{4, 1};
  int inv_p [2] = '{0, 1};
  bit model_valid = 1'b0;

  function automatic int gidx(input logic a, input logic b);
    case ({a, b})
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int g);
    case (g)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Output flips when the last FILT_LEN synchronised samples all disagree with it.
  function automatic logic filt_next(input logic [15:0] h, input logic f, input int s, input int fl);
    logic flip;
    flip = 1'b1;
    for (int j = 0; j < fl; j++) if (h[s+j] == f) flip = 1'b0;
    return flip ? ~f : f;
  endfunction

  task automatic model_edge(input int i);
    mdl_t s;
    int d;
    logic zedge;
    s = m[i];
    if (rst) begin
      s = '0;
      s.init_left = 8'(s_p[i] + f_p[i] + 1);
    end else begin
      s.step = 1'b0;
      if (!s.run) begin
        if (clr) begin s.cnt = 16'd0; s.idx = 1'b0; end
        if (err_clr) s.err = 1'b0;
        s.init_left = s.init_left - 8'd1;
        if (s.init_left == 8'd0) s.run = 1'b1;
      end else begin
        d = (gidx(s.fa, s.fb) - gidx(s.pa, s.pb) + 4) % 4;
        zedge = IDX_EN && s.fz && !s.pz;
        if (clr) begin
          s.cnt = 16'd0; s.idx = 1'b0;
        end else if (zedge) begin
          s.cnt = 16'd0; s.idx = 1'b1;
        end else if (d == 1) begin
          s.cnt = s.cnt + 16'd1; s.dir = (inv_p[i] == 0); s.step = 1'b1;
        end else if (d == 3) begin
          s.cnt = s.cnt - 16'd1; s.dir = (inv_p[i] != 0); s.step = 1'b1;
        end
        if (d == 2) s.err = 1'b1;
        else if (err_clr) s.err = 1'b0;
      end
      s.pa = s.fa; s.pb = s.fb; s.pz = s.fz;
      s.ha = {s.ha[14:0], enc_a};
      s.hb = {s.hb[14:0], enc_b};
      s.hz = {s.hz[14:0], enc_z};
      s.fa = filt_next(s.ha, s.fa, s_p[i], f_p[i]);
      s.fb = filt_next(s.hb, s.fb, s_p[i], f_p[i]);
      s.fz = filt_next(s.hz, s.fz, s_p[i], f_p[i]);
    end
    m[i] = s;
  endtask

  task automatic model_step();
    model_edge(0);
    model_edge(1);
    if (rst) model_valid = 1'b1;
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      if (a_step) steps_a++;
      chk("a_count", a_count, m[0].cnt);
      chk("a_dir",   16'(a_dir),  16'(m[0].dir));
      chk("a_step",  16'(a_step), 16'(m[0].step));
      chk("a_err",   16'(a_err),  16'(m[0].err));
      chk("b_count", b_count, m[1].cnt);
      chk("b_dir",   16'(b_dir),  16'(m[1].dir));
      chk("b_step",  16'(b_step), 16'(m[1].step));
      chk("b_err",   16'(b_err),  16'(m[1].err));
`ifdef QUAD_INDEX_EN
      chk("a_index", 16'(a_idx), 16'(m[0].idx));
      chk("b_index", 16'(b_idx), 16'(m[1].idx));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int g, input int hold);
    cur_g = g;
    {enc_a, enc_b} = ab_of(g);
    tick(hold);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  initial begin
    #3_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int s0;
    int r;
    int hold;
    rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_z = 1'b0;
    clr = 1'b0; err_clr = 1'b0; cur_g = 2;
    tick(3);
    chk("rst_count", a_count, 16'd0);
    chk("rst_dir",   16'(a_dir),  16'd0);
    chk("rst_step",  16'(a_step), 16'd0);
    chk("rst_err",   16'(a_err),  16'd0);
    rst = 1'b0;
    tick(12);
    chk("init_count", a_count, 16'd0);
    chk("init_err",   16'(a_err), 16'd0);
    chk("init_count_b", b_count, 16'd0);

    // full forward cycle from 11
    s0 = steps_a;
    go(3, 10); go(0, 10); go(1, 10); go(2, 10);
    chk("fwd_count", a_count, 16'd4);
    chk("fwd_dir",   16'(a_dir), 16'd1);
    chk("fwd_steps", 16'(steps_a - s0), 16'd4);
    chk("fwd_err",   16'(a_err), 16'd0);
    chk("fwd_count_b", b_count, 16'd4);
    chk("fwd_dir_inv", 16'(b_dir), 16'd0);

    // back to 00, clear, then two reverse cycles
    go(1, 10); go(0, 10);
    chk("pre_clr_count", a_count, 16'd2);
    pulse_clr();
    chk("clr_count", a_count, 16'd0);
    tick(9);
    repeat (2) begin
      go(3, 10); go(2, 10); go(1, 10); go(0, 10);
    end
    chk("rev_count", a_count, 16'hFFF8);
    chk("rev_dir",   16'(a_dir), 16'd0);
    chk("rev_count_b", b_count, 16'hFFF8);
    chk("rev_dir_inv", 16'(b_dir), 16'd1);

    // 3-clock glitch on A is dropped, 4-clock levels are taken
    s0 = steps_a;
    go(3, 3); go(0, 10);
    chk("glitch_count", a_count, 16'hFFF8);
    chk("glitch_err",   16'(a_err), 16'd0);
    chk("glitch_steps", 16'(steps_a - s0), 16'd0);
    go(1, 10); go(2, 4); go(3, 10);
    chk("stable_count", a_count, 16'hFFFB);
    chk("stable_steps", 16'(steps_a - s0), 16'd3);

    // illegal transitions and err_clr priority
    go(1, 10);
    chk("ill_err",   16'(a_err), 16'd1);
    chk("ill_count", a_count, 16'hFFFB);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr_alone", 16'(a_err), 16'd0);
    tick(5);
    go(3, 6);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr_set_wins", 16'(a_err), 16'd1);
    tick(5);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("errclr_again", 16'(a_err), 16'd0);

    // wrap on the unfiltered instance: one level per clock
    tick(5);
    pulse_clr();
    tick(10);
    for (int k = 0; k < 32767; k++) go((cur_g + 1) % 4, 1);
    tick(10);
    chk("wrap_pre", b_count, 16'h7FFF);
    go((cur_g + 1) % 4, 10);
    chk("wrap_pos", b_count, 16'h8000);

    // clr on the same edge as a step on instance b (5-edge latency)
    go(0, 4);
    pulse_clr();
    chk("clrstep_count", b_count, 16'd0);
    chk("clrstep_step",  16'(b_step), 16'd0);
    tick(10);
    chk("clrstep_hold", b_count, 16'd0);
    go(3, 10);
    chk("wrap_neg", b_count, 16'hFFFF);
    chk("wrap_neg_dir", 16'(b_dir), 16'd1);

`ifdef QUAD_INDEX_EN
    pulse_clr();
    tick(10);
    for (int k = 0; k < 37; k++) go((cur_g + 1) % 4, 6);
    tick(4);
    chk("idx_pre", a_count, 16'd37);
    enc_z = 1'b1;
    go((cur_g + 1) % 4, 10);
    chk("idx_count",  a_count, 16'd0);
    chk("idx_seen",   16'(a_idx), 16'd1);
    chk("idx_count_b", b_count, 16'd0);
    enc_z = 1'b0;
    tick(10);
    pulse_clr();
    chk("idx_clr", 16'(a_idx), 16'd0);
`endif

    // randomized walk: legal steps, illegal jumps, glitches, clears, resets
    for (int it = 0; it < 1500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1'b1; tick(2); rst = 1'b0;
      end else if (r < 12) begin
        cur_g = (cur_g + 2) % 4;
      end else if (r < 55) begin
        cur_g = (cur_g + 1) % 4;
      end else if (r < 95) begin
        cur_g = (cur_g + 3) % 4;
      end
      {enc_a, enc_b} = ab_of(cur_g);
`ifdef QUAD_INDEX_EN
      if ($urandom_range(0, 7) == 0) enc_z = ~enc_z;
`endif
      clr = ($urandom_range(0, 19) == 0);
      err_clr = ($urandom_range(0, 9) == 0);
      hold = $urandom_range(1, 8);
      tick(1);
      clr = 1'b0;
      err_clr = 1'b0;
      tick(hold - 1);
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
